// File: rtl/mbinit_sb_pkg.sv
// ---------------------------------------------------------------------------
// mbinit_sb_pkg
//   Shared definitions for the MBINIT sideband TX path:
//     - sideband message codes used by the MBINIT substate requesters
//     - requester id constants (arbiter port index of each substate FSM)
//     - FSM state encoding of the TX arbiter
//     - small helper for wrapping round-robin pointers
// ---------------------------------------------------------------------------
package mbinit_sb_pkg;

  // REPAIRMB sideband message codes
  localparam logic [3:0] MSG_RMB_START_REQ          = 4'b0001;
  localparam logic [3:0] MSG_RMB_START_RESP         = 4'b0010;
  localparam logic [3:0] MSG_RMB_END_REQ            = 4'b0011;
  localparam logic [3:0] MSG_RMB_END_RESP           = 4'b0100;
  localparam logic [3:0] MSG_RMB_APPLY_DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] MSG_RMB_APPLY_DEGRADE_RESP = 4'b0110;

  // Requester ids: the arbiter port each substate FSM is wired to
  localparam logic [2:0] ID_PARAM      = 3'd0;
  localparam logic [2:0] ID_CAL        = 3'd1;
  localparam logic [2:0] ID_REPAIRCLK  = 3'd2;
  localparam logic [2:0] ID_REPAIRVAL  = 3'd3;
  localparam logic [2:0] ID_REVERSALMB = 3'd4;
  localparam logic [2:0] ID_REPAIRMB   = 3'd5;

  // Arbiter FSM encoding
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd3;
  localparam logic [ST_W-1:0] ST_COMPLETE  = 3'd4;

  // Next index after id in a ring of num entries
  function automatic int wrap_inc(input int id, input int num);
    return (id >= num - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/mbinit_rr_pick.sv
// ---------------------------------------------------------------------------
// mbinit_rr_pick
//   Combinational round-robin select. Returns the first set bit of pending
//   at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
// Ports
//   pending  in   NUM_REQ  requesters waiting for the sideband
//   rr_ptr   in   ID_W     highest-priority index (must be < NUM_REQ)
//   grant    out  ID_W     selected requester (0 when nothing pending)
//   any      out  1        at least one requester pending
// ---------------------------------------------------------------------------
module mbinit_rr_pick #(
  parameter int NUM_REQ = 6,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any
);

  // Walk the ring from the farthest offset down to rr_ptr itself so the
  // closest set bit is the last one written.
  always_comb begin
    int          sum;
    logic [ID_W-1:0] idx;
    grant = '0;
    any   = |pending;
    sum   = 0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (pending[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mbinit_sb_tx_arbiter
//   Shares the single sideband TX message port among the MBINIT substate
//   FSMs. Each requester's one-cycle pulse is latched (code + info), pending
//   requests are granted round-robin, and the owner sees a busy level until
//   the sideband finishes serialising, then a one-cycle falling-edge pulse.
//   ID_W must satisfy 2**ID_W >= NUM_REQ; ACK_TIMEOUT must be 1..255.
// Ports
//   CLK                  in   clock
//   rst_n                in   async active-low reset
//   i_enable             in   LTSM in MBINIT; low flushes all pending work
//   i_req_valid          in   one-cycle request pulse per requester
//   i_req_msg            in   flattened msg codes, requester i at [i*MSG_W +: MSG_W]
//   i_req_info           in   flattened msg info, same packing
//   i_sb_busy            in   sideband TX serialising
//   o_sb_valid           out  one-cycle issue strobe
//   o_sb_msg/info/src    out  granted message, held until the next issue
//   o_busy               out  per-requester busy level
//   o_falling_edge_busy  out  one-cycle completion pulse to the owner
//   o_drop_err           out  pulse: request arrived while requester busy
//   o_timeout_err        out  pulse: sideband never acknowledged the issue
// ---------------------------------------------------------------------------
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter int NUM_REQ     = 6,
  parameter int MSG_W       = 4,
  parameter int INFO_W      = 3,
  parameter int ID_W        = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*MSG_W-1:0]  i_req_msg,
  input  logic [NUM_REQ*INFO_W-1:0] i_req_info,
  input  logic                      i_sb_busy,
  output logic                      o_sb_valid,
  output logic [MSG_W-1:0]          o_sb_msg,
  output logic [INFO_W-1:0]         o_sb_info,
  output logic [ID_W-1:0]           o_sb_src,
  output logic [NUM_REQ-1:0]        o_busy,
  output logic [NUM_REQ-1:0]        o_falling_edge_busy,
  output logic                      o_drop_err,
  output logic                      o_timeout_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [ST_W-1:0]    state, state_nxt;
  logic [NUM_REQ-1:0] pending, pending_nxt;
  logic [ID_W-1:0]    owner, owner_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_nxt;
  logic [7:0]         ack_cnt, cnt_nxt, cnt_inc;
  logic [MSG_W-1:0]   msg_q  [NUM_REQ];
  logic [INFO_W-1:0]  info_q [NUM_REQ];

  logic [ID_W-1:0]    grant, owner_inc;
  logic               grant_any;
  logic [NUM_REQ-1:0] owner_oh, owner_oh_nxt, complete_oh;
  logic [NUM_REQ-1:0] accept, busy_nxt, feb_nxt;
  logic               issue, drop_nxt, timeout_nxt;

  mbinit_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .any     (grant_any)
  );

  assign owner_inc = ID_W'(wrap_inc(int'(owner), NUM_REQ));
  assign cnt_inc   = (ack_cnt == 8'hFF) ? ack_cnt : ack_cnt + 8'd1;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == ID_W'(i));
  end

  // The owner may re-arm itself in its COMPLETE cycle even though its busy
  // level is still high; everyone else busy gets dropped.
  assign complete_oh = owner_oh & {NUM_REQ{state == ST_COMPLETE}};
  assign accept      = {NUM_REQ{i_enable}} & i_req_valid & (~o_busy | complete_oh);
  assign drop_nxt    = i_enable & (|(i_req_valid & o_busy & ~complete_oh));

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    cnt_nxt     = ack_cnt;
    issue       = 1'b0;
    timeout_nxt = 1'b0;
    feb_nxt     = '0;
    if (!i_enable) begin
      state_nxt   = ST_IDLE;
      pending_nxt = '0;
      owner_nxt   = '0;
      cnt_nxt     = '0;
    end else begin
      case (state)
        // Waiting for ~i_sb_busy also lets a message aborted by a flush
        // finish draining before anything new goes out.
        ST_IDLE: begin
          if (grant_any && !i_sb_busy) begin
            state_nxt = ST_ISSUE;
            owner_nxt = grant;
            issue     = 1'b1;
          end
        end
        ST_ISSUE: begin
          state_nxt = ST_WAIT_ACK;
          cnt_nxt   = '0;
        end
        // Fires on the incremented count so the error pulse lands
        // ACK_TIMEOUT cycles after the issue strobe.
        ST_WAIT_ACK: begin
          if (i_sb_busy) begin
            state_nxt = ST_WAIT_DONE;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= TIMEOUT_LAST) begin
              timeout_nxt = 1'b1;
              pending_nxt = pending & ~owner_oh;
              rr_nxt      = owner_inc;
              state_nxt   = ST_IDLE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!i_sb_busy) begin
            state_nxt = ST_COMPLETE;
            feb_nxt   = owner_oh;
          end
        end
        ST_COMPLETE: begin
          pending_nxt = pending & ~owner_oh;
          rr_nxt      = owner_inc;
          state_nxt   = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
      // New requests are merged last so a same-cycle re-arm beats the clear.
      pending_nxt = pending_nxt | accept;
    end
  end

  always_comb begin
    owner_oh_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh_nxt[i] = (owner_nxt == ID_W'(i));
  end

  assign busy_nxt = pending_nxt | (owner_oh_nxt & {NUM_REQ{state_nxt != ST_IDLE}});

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      pending             <= '0;
      owner               <= '0;
      rr_ptr              <= '0;
      ack_cnt             <= '0;
      o_sb_valid          <= 1'b0;
      o_sb_msg            <= '0;
      o_sb_info           <= '0;
      o_sb_src            <= '0;
      o_busy              <= '0;
      o_falling_edge_busy <= '0;
      o_drop_err          <= 1'b0;
      o_timeout_err       <= 1'b0;
    end else begin
      state               <= state_nxt;
      pending             <= pending_nxt;
      owner               <= owner_nxt;
      rr_ptr              <= rr_nxt;
      ack_cnt             <= cnt_nxt;
      o_sb_valid          <= issue;
      o_busy              <= busy_nxt;
      o_falling_edge_busy <= feb_nxt;
      o_drop_err          <= drop_nxt;
      o_timeout_err       <= timeout_nxt;
      if (issue) begin
        o_sb_msg  <= msg_q[grant];
        o_sb_info <= info_q[grant];
        o_sb_src  <= grant;
      end
    end
  end

  // Payload is captured with the request pulse; requesters need not hold it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        msg_q[i]  <= '0;
        info_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          msg_q[i]  <= i_req_msg[i*MSG_W +: MSG_W];
          info_q[i] <= i_req_info[i*INFO_W +: INFO_W];
        end
      end
    end
  end

endmodule
